// File: rtl/game_ctrl.sv
//==============================================================================
// Module      : game_ctrl
// Description : Game flow controller: IDLE/PLAY/HIT/OVER state machine with
//               per-frame move grants, lives and a saturating score counter.
//               Optional PAUSE state is built when GAME_CTRL_PAUSE_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module game_ctrl #(
    parameter int P_LIVES      = 3,
    parameter int P_SCORE_DIV  = 60,
    parameter int P_HIT_FRAMES = 120,
    parameter int P_X_MAX      = 616
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_fTick,
    input  logic        i_Btn_Left,
    input  logic        i_Btn_Right,
    input  logic        i_Btn_Start,
    input  logic        i_Hit,
    input  logic [9:0]  i_Player_Position,
    output logic        o_Move_Left,
    output logic        o_Move_Right,
    output logic [2:0]  o_State,
    output logic [1:0]  o_Lives,
    output logic [13:0] o_Score,
    output logic        o_Game_Over
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_PLAY  = 3'd1;
    localparam logic [2:0] c_ST_HIT   = 3'd2;
    localparam logic [2:0] c_ST_OVER  = 3'd3;
`ifdef GAME_CTRL_PAUSE_EN
    localparam logic [2:0] c_ST_PAUSE = 3'd4;
`endif

    localparam int c_SCW = (P_SCORE_DIV  > 1) ? $clog2(P_SCORE_DIV)  : 1;
    localparam int c_HCW = (P_HIT_FRAMES > 1) ? $clog2(P_HIT_FRAMES) : 1;

    localparam logic [1:0]       c_LIVES      = 2'(P_LIVES);
    localparam logic [c_SCW-1:0] c_SCORE_LAST = c_SCW'(P_SCORE_DIV - 1);
    localparam logic [c_HCW-1:0] c_HIT_LAST   = c_HCW'(P_HIT_FRAMES - 1);
    localparam logic [9:0]       c_X_MAX      = 10'(P_X_MAX);
    localparam logic [13:0]      c_SCORE_MAX  = 14'd9999;

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic             r_ftick_q;
    logic             r_start_q;
    logic             w_ftick_edge;
    logic             w_start_edge;
    logic [c_SCW-1:0] r_score_cnt;
    logic [c_HCW-1:0] r_hit_cnt;
    logic [1:0]       r_lives;
    logic [13:0]      r_score;
    logic             r_move_left;
    logic             r_move_right;
    logic             w_play_frame;
    logic             w_hit_done;
    logic             w_grant_left;
    logic             w_grant_right;

    assign w_ftick_edge = i_fTick & ~r_ftick_q;
    assign w_start_edge = i_Btn_Start & ~r_start_q;
    assign w_hit_done   = w_ftick_edge && (r_hit_cnt == c_HIT_LAST);

    // A frame only counts when PLAY is kept; a hit (or pause) that frame cancels it.
    assign w_play_frame = (r_state == c_ST_PLAY) && (w_next_state == c_ST_PLAY) && w_ftick_edge;

    // State register
    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start_edge) begin
                    w_next_state = c_ST_PLAY;
                end
            end
            c_ST_PLAY: begin
                if (i_Hit) begin
                    w_next_state = (r_lives <= 2'd1) ? c_ST_OVER : c_ST_HIT;
                end
`ifdef GAME_CTRL_PAUSE_EN
                else if (w_start_edge) begin
                    w_next_state = c_ST_PAUSE;
                end
`endif
            end
            c_ST_HIT: begin
                if (w_hit_done) begin
                    w_next_state = c_ST_PLAY;
                end
            end
            c_ST_OVER: begin
                if (w_start_edge) begin
                    w_next_state = c_ST_IDLE;
                end
            end
`ifdef GAME_CTRL_PAUSE_EN
            c_ST_PAUSE: begin
                if (w_start_edge) begin
                    w_next_state = c_ST_PLAY;
                end
            end
`endif
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        o_State       = r_state;
        o_Game_Over   = (r_state == c_ST_OVER);
        o_Lives       = r_lives;
        o_Score       = r_score;
        o_Move_Left   = r_move_left;
        o_Move_Right  = r_move_right;
        w_grant_left  = w_play_frame && i_Btn_Left && !i_Btn_Right
                        && (i_Player_Position != 10'd0);
        w_grant_right = w_play_frame && i_Btn_Right && !i_Btn_Left
                        && (i_Player_Position < c_X_MAX);
    end

    // Edge history, grants, lives, score and frame counters
    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            r_ftick_q    <= 1'b0;
            r_start_q    <= 1'b0;
            r_move_left  <= 1'b0;
            r_move_right <= 1'b0;
            r_lives      <= 2'd0;
            r_score      <= 14'd0;
            r_score_cnt  <= '0;
            r_hit_cnt    <= '0;
        end else begin
            r_ftick_q    <= i_fTick;
            r_start_q    <= i_Btn_Start;
            r_move_left  <= w_grant_left;
            r_move_right <= w_grant_right;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_start_edge) begin
                        r_lives     <= c_LIVES;
                        r_score     <= 14'd0;
                        r_score_cnt <= '0;
                        r_hit_cnt   <= '0;
                    end
                end
                c_ST_PLAY: begin
                    if (i_Hit) begin
                        r_lives   <= r_lives - 2'd1;
                        r_hit_cnt <= '0;
                    end else if (w_play_frame) begin
                        if (r_score_cnt == c_SCORE_LAST) begin
                            r_score_cnt <= '0;
                            if (r_score != c_SCORE_MAX) begin
                                r_score <= r_score + 14'd1;
                            end
                        end else begin
                            r_score_cnt <= r_score_cnt + 1'b1;
                        end
                    end
                end
                c_ST_HIT: begin
                    if (w_hit_done) begin
                        r_hit_cnt <= '0;
                    end else if (w_ftick_edge) begin
                        r_hit_cnt <= r_hit_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_game_ctrl.sv
//==============================================================================
// Module      : tb_game_ctrl
// Description : Directed self-checking bench for game_ctrl (default parameters).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_game_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ftick;
    logic        btn_l;
    logic        btn_r;
    logic        btn_s;
    logic        hit;
    logic [9:0]  pos;
    logic        mv_l;
    logic        mv_r;
    logic [2:0]  state;
    logic [1:0]  lives;
    logic [13:0] score;
    logic        gover;

    int total = 0;
    int bad   = 0;

    game_ctrl dut (
        .i_Clk             (clk),
        .i_Rst             (rst_n),
        .i_fTick           (ftick),
        .i_Btn_Left        (btn_l),
        .i_Btn_Right       (btn_r),
        .i_Btn_Start       (btn_s),
        .i_Hit             (hit),
        .i_Player_Position (pos),
        .o_Move_Left       (mv_l),
        .o_Move_Right      (mv_r),
        .o_State           (state),
        .o_Lives           (lives),
        .o_Score           (score),
        .o_Game_Over       (gover)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One fTick rising edge; grant checked the cycle after, then checked gone.
    task automatic frame(input logic el, input logic er, input string tag);
        @(negedge clk); ftick = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_left"}, 32'(mv_l), 32'(el));
        chk({tag, "_right"}, 32'(mv_r), 32'(er));
        @(negedge clk); ftick = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_off"}, {30'd0, mv_l, mv_r}, 32'd0);
    endtask

    task automatic start_pulse();
        @(negedge clk); btn_s = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); btn_s = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; ftick = 1'b0; btn_l = 1'b0; btn_r = 1'b0;
        btn_s = 1'b0; hit = 1'b0; pos = 10'd320;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_lives", 32'(lives), 32'd0);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_grants", {30'd0, mv_l, mv_r}, 32'd0);
        chk("rst_gover", 32'(gover), 32'd0);

        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); btn_s = 1'b1;
        @(posedge clk); #1;
        chk("start_state", 32'(state), 32'd1);
        chk("start_lives", 32'(lives), 32'd3);
        chk("start_score", 32'(score), 32'd0);
        @(negedge clk); btn_s = 1'b0;

        btn_l = 1'b1;
        frame(1'b1, 1'b0, "left320");
        btn_r = 1'b1;
        frame(1'b0, 1'b0, "both");
        btn_l = 1'b0;
        frame(1'b0, 1'b1, "right320");
        btn_r = 1'b0; btn_l = 1'b1; pos = 10'd0;
        frame(1'b0, 1'b0, "left_at0");
        btn_l = 1'b0; btn_r = 1'b1; pos = 10'd616;
        frame(1'b0, 1'b0, "right_at616");
        btn_r = 1'b0; btn_l = 1'b1;
        frame(1'b1, 1'b0, "left_at616");
        btn_l = 1'b0; pos = 10'd320;

        // Six frames so far; 53 more leaves the score one frame short of a point.
        for (int i = 0; i < 53; i++) frame(1'b0, 1'b0, "play_idle");
        chk("score_59", 32'(score), 32'd0);
        frame(1'b0, 1'b0, "frame60");
        chk("score_60", 32'(score), 32'd1);
        for (int i = 0; i < 60; i++) frame(1'b0, 1'b0, "play_idle");
        chk("score_120", 32'(score), 32'd2);

`ifdef GAME_CTRL_PAUSE_EN
        start_pulse();
        chk("pause_state", 32'(state), 32'd4);
        btn_l = 1'b1;
        for (int i = 0; i < 60; i++) frame(1'b0, 1'b0, "pause_frame");
        chk("pause_score", 32'(score), 32'd2);
        btn_l = 1'b0;
        start_pulse();
        chk("unpause_state", 32'(state), 32'd1);
`else
        start_pulse();
        chk("start_in_play", 32'(state), 32'd1);
`endif

        // Hit coincident with a frame tick, left held: hit wins.
        btn_l = 1'b1;
        @(negedge clk); hit = 1'b1; ftick = 1'b1;
        @(posedge clk); #1;
        chk("hit1_lives", 32'(lives), 32'd2);
        chk("hit1_state", 32'(state), 32'd2);
        chk("hit1_grant", {30'd0, mv_l, mv_r}, 32'd0);
        @(negedge clk); ftick = 1'b0;
        @(posedge clk); #1;
        chk("hit_ignored_lives", 32'(lives), 32'd2);
        chk("hit1_grant_next", {30'd0, mv_l, mv_r}, 32'd0);
        @(negedge clk); hit = 1'b0;
        chk("hit1_score", 32'(score), 32'd2);

        for (int i = 0; i < 119; i++) frame(1'b0, 1'b0, "hit_frame");
        chk("hit_119_state", 32'(state), 32'd2);
        frame(1'b0, 1'b0, "hit_frame120");
        chk("hit_done_state", 32'(state), 32'd1);
        btn_l = 1'b0;

        @(negedge clk); hit = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); hit = 1'b0;
        chk("hit2_lives", 32'(lives), 32'd1);
        chk("hit2_state", 32'(state), 32'd2);
        for (int i = 0; i < 120; i++) frame(1'b0, 1'b0, "hit2_frame");
        chk("hit2_done_state", 32'(state), 32'd1);

        @(negedge clk); hit = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); hit = 1'b0;
        chk("hit3_lives", 32'(lives), 32'd0);
        chk("over_state", 32'(state), 32'd3);
        chk("over_gover", 32'(gover), 32'd1);
        btn_r = 1'b1;
        for (int i = 0; i < 60; i++) frame(1'b0, 1'b0, "over_frame");
        btn_r = 1'b0;
        chk("over_score_frozen", 32'(score), 32'd2);

        start_pulse();
        chk("over_to_idle", 32'(state), 32'd0);
        chk("idle_gover", 32'(gover), 32'd0);
        start_pulse();
        chk("restart_state", 32'(state), 32'd1);
        chk("restart_lives", 32'(lives), 32'd3);
        chk("restart_score", 32'(score), 32'd0);

        // Reset mid-HIT.
        @(negedge clk); hit = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); hit = 1'b0;
        chk("hit4_state", 32'(state), 32'd2);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_hit_state", 32'(state), 32'd0);
        chk("rst_hit_lives", 32'(lives), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Reset coinciding with a would-be grant frame in PLAY.
        start_pulse();
        chk("replay_state", 32'(state), 32'd1);
        btn_l = 1'b1;
        @(negedge clk); rst_n = 1'b0; ftick = 1'b1;
        @(posedge clk); #1;
        chk("rst_play_state", 32'(state), 32'd0);
        chk("rst_play_grant", {30'd0, mv_l, mv_r}, 32'd0);
        @(negedge clk); ftick = 1'b0; btn_l = 1'b0;
        @(posedge clk); #1;
        chk("rst_play_grant_next", {30'd0, mv_l, mv_r}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
